// File: rtl/fp_align_pkg.sv
// Shared constants and types for the FP adder alignment stage.
package fp_align_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXT_W  = FP_MANT_W + 4;
    localparam int FP_STEP   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } operand_t;

endpackage

// File: rtl/fp_align_shifter_sticky_shift_right.sv
// Combinational right shift by 0..STEP bits; every bit shifted out is ORed into bit 0.
module sticky_shift_right #(
    parameter int W    = 27,
    parameter int STEP = 4,
    parameter int SH_W = $clog2(STEP + 1)
) (
    input  logic [W-1:0]    data_in,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    data_out
);

    logic [W-1:0] shifted;
    logic         lost;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        lost = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(shamt)) lost = lost | data_in[i];
        end
        shifted  = data_in >> shamt;
        data_out = {shifted[W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/fp_align_shifter.sv
// Alignment stage of the single-precision FP adder: restores hidden bits and iteratively
// right-shifts the smaller mantissa by the exponent difference, keeping a sticky bit.
import fp_align_pkg::*;

module fp_align_shifter #(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int STEP   = FP_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  swap_sign_A,
    input  logic                  swap_sign_B,
    input  logic [EXP_W-1:0]      swap_exp_A,
    input  logic [EXP_W-1:0]      swap_exp_B,
    input  logic [MANT_W-1:0]     swap_mant_A,
    input  logic [MANT_W-1:0]     swap_mant_B,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic                  out_eff_sub,
    output logic [EXP_W-1:0]      out_exp,
    output logic [MANT_W+3:0]     out_mant_A,
    output logic [MANT_W+3:0]     out_mant_B,
    output logic                  order_err
);

    localparam int EXT_W = MANT_W + 4;
    localparam int REM_W = $clog2(EXT_W + 1);
    localparam int SH_W  = $clog2(STEP + 1);
    localparam logic [EXP_W:0] EXT_LIM  = (EXP_W + 1)'(EXT_W);
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               sign_q, sign_d;
    logic               eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [EXT_W-1:0]   mant_a_q, mant_a_d;
    logic [EXT_W-1:0]   mant_b_q, mant_b_d;
    logic               order_err_q, order_err_d;

    logic [EXP_W-1:0]   exp_a_eff, exp_b_eff;
    logic [EXP_W:0]     exp_diff;
    logic [REM_W-1:0]   dist_in;
    logic [REM_W-1:0]   step_k;
    logic [EXT_W-1:0]   mant_b_shifted;

    // Denormals (exp==0) behave as exponent 1 without the hidden bit.
    always_comb begin
        exp_a_eff = (swap_exp_A == '0) ? EXP_W'(1) : swap_exp_A;
        exp_b_eff = (swap_exp_B == '0) ? EXP_W'(1) : swap_exp_B;
        exp_diff  = {1'b0, exp_a_eff} - {1'b0, exp_b_eff};
        if (exp_diff[EXP_W]) begin
            dist_in = '0;
        end else if (exp_diff > EXT_LIM) begin
            dist_in = REM_W'(EXT_W);
        end else begin
            dist_in = exp_diff[REM_W-1:0];
        end
        step_k = (rem_q > STEP_R) ? STEP_R : rem_q;
    end

    sticky_shift_right #(
        .W    (EXT_W),
        .STEP (STEP),
        .SH_W (SH_W)
    ) u_shift (
        .data_in  (mant_b_q),
        .shamt    (step_k[SH_W-1:0]),
        .data_out (mant_b_shifted)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        order_err_d = order_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d      = swap_sign_A;
                    eff_sub_d   = sub ^ swap_sign_A ^ swap_sign_B;
                    exp_d       = exp_a_eff;
                    mant_a_d    = {swap_exp_A != '0, swap_mant_A, 3'b000};
                    mant_b_d    = {swap_exp_B != '0, swap_mant_B, 3'b000};
                    order_err_d = exp_diff[EXP_W];
                    rem_d       = dist_in;
                    state_d     = (dist_in != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                mant_b_d = mant_b_shifted;
                rem_d    = rem_q - step_k;
                if (rem_q == step_k) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset clears every register asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            mant_a_q    <= mant_a_d;
            mant_b_q    <= mant_b_d;
            order_err_q <= order_err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_sign    = sign_q;
    assign out_eff_sub = eff_sub_q;
    assign out_exp     = exp_q;
    assign out_mant_A  = mant_a_q;
    assign out_mant_B  = mant_b_q;
    assign order_err   = order_err_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Self-checking bench for fp_align_shifter: directed cases plus randomized operands
// compared against an arithmetic reference model.
import fp_align_pkg::*;

module tb_fp_align_shifter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 swap_sign_A, swap_sign_B;
    logic [FP_EXP_W-1:0]  swap_exp_A, swap_exp_B;
    logic [FP_MANT_W-1:0] swap_mant_A, swap_mant_B;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign, out_eff_sub;
    logic [FP_EXP_W-1:0]  out_exp;
    logic [FP_EXT_W-1:0]  out_mant_A, out_mant_B;
    logic                 order_err;

    int n_checks = 0;
    int n_fail   = 0;

    fp_align_shifter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .swap_sign_A (swap_sign_A),
        .swap_sign_B (swap_sign_B),
        .swap_exp_A  (swap_exp_A),
        .swap_exp_B  (swap_exp_B),
        .swap_mant_A (swap_mant_A),
        .swap_mant_B (swap_mant_B),
        .sub         (sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_eff_sub (out_eff_sub),
        .out_exp     (out_exp),
        .out_mant_A  (out_mant_A),
        .out_mant_B  (out_mant_B),
        .order_err   (order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic operand_t mk(input logic s, input int e, input int m);
        operand_t o;
        o.sign = s;
        o.exp  = FP_EXP_W'(e);
        o.mant = FP_MANT_W'(m);
        return o;
    endfunction

    task automatic drive_op(input operand_t a, input operand_t b, input logic sub_i);
        swap_sign_A = a.sign;
        swap_exp_A  = a.exp;
        swap_mant_A = a.mant;
        swap_sign_B = b.sign;
        swap_exp_B  = b.exp;
        swap_mant_B = b.mant;
        sub         = sub_i;
    endtask

    // Reference: full-width align by integer division of the exponent gap, no iteration.
    task automatic run_op(input operand_t a, input operand_t b, input logic sub_i, input int hold);
        int ea, eb, d, lat, cyc;
        longint unsigned a_ext, b_ext, b_exp, lost;
        bit oerr;
        ea    = (a.exp == 0) ? 1 : int'(a.exp);
        eb    = (b.exp == 0) ? 1 : int'(b.exp);
        d     = ea - eb;
        oerr  = (d < 0);
        if (d < 0) d = 0;
        if (d > FP_EXT_W) d = FP_EXT_W;
        a_ext = ((a.exp != 0) ? (64'd1 << (FP_EXT_W - 1)) : 64'd0) + (longint'(a.mant) << 3);
        b_ext = ((b.exp != 0) ? (64'd1 << (FP_EXT_W - 1)) : 64'd0) + (longint'(b.mant) << 3);
        lost  = b_ext % (64'd1 << d);
        b_exp = (b_ext >> d) | ((lost != 0) ? 64'd1 : 64'd0);
        lat   = (d == 0) ? 1 : ((d + FP_STEP - 1) / FP_STEP) + 1;

        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        drive_op(a, b, sub_i);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid", out_valid, 1);
        check("latency", longint'(cyc), longint'(lat));
        check("out_mant_A", out_mant_A, a_ext);
        check("out_mant_B", out_mant_B, b_exp);
        check("out_exp", out_exp, longint'(ea));
        check("out_sign", out_sign, a.sign);
        check("out_eff_sub", out_eff_sub, sub_i ^ a.sign ^ b.sign);
        check("order_err", order_err, oerr);
        check("in_ready_busy", in_ready, 0);

        for (int h = 0; h < hold; h++) begin
            drive_op(mk($urandom_range(0, 1), $urandom_range(0, 255), int'($urandom)),
                     mk($urandom_range(0, 1), $urandom_range(0, 255), int'($urandom)),
                     $urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_mant_B", out_mant_B, b_exp);
            check("hold_mant_A", out_mant_A, a_ext);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        operand_t a, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_op(mk(0, 0, 0), mk(0, 0, 0), 1'b0);
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mant_A", out_mant_A, 0);
        check("rst_mant_B", out_mant_B, 0);
        check("rst_exp", out_exp, 0);
        check("rst_order_err", order_err, 0);
        rst = 1'b0;

        run_op(mk(0, 129, 'h5CCCCD), mk(0, 129, 'h066666), 1'b0, 0);
        run_op(mk(0, 129, 'h066666), mk(0, 126, 'h30A3D7), 1'b1, 0);
        run_op(mk(0, 200, 0), mk(1, 100, 0), 1'b0, 0);
        run_op(mk(0, 1, 0), mk(0, 0, 1), 1'b0, 0);
        run_op(mk(1, 3, 'h123456), mk(0, 5, 'h000F0F), 1'b0, 0);
        run_op(mk(0, 0, 'h7FFFFF), mk(0, 0, 0), 1'b1, 1);
        run_op(mk(0, 129, 'h066666), mk(0, 126, 'h30A3D7), 1'b1, 5);

        // Reset in the middle of a 27-bit shift must discard the result at once.
        @(negedge clk);
        drive_op(mk(0, 200, 0), mk(0, 100, 0), 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_shift_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_mant_B", out_mant_B, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(mk(0, 129, 'h5CCCCD), mk(0, 129, 'h066666), 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            int ea, eb, mb;
            ea = $urandom_range(0, 255);
            mb = int'($urandom);
            case ($urandom_range(0, 3))
                0: eb = (ea > 30) ? ea - int'($urandom_range(0, 30)) : 0;
                1: eb = $urandom_range(0, 255);
                2: eb = ea;
                default: begin
                    eb = 0;
                    if ($urandom_range(0, 1) == 1) mb = 0;
                end
            endcase
            a = mk($urandom_range(0, 1), ea, int'($urandom));
            b = mk($urandom_range(0, 1), eb, mb);
            run_op(a, b, $urandom_range(0, 1), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
